regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the core's 3-port file.
- Replaces the negedge-write pipeline trick with posedge writes plus optional internal write-to-read forwarding.
- Adds N read / M write ports, asynchronous clear, and a per-register pending-write scoreboard for hazard detection in the decode stage.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), address width.
- NR, 2, number of read ports.
- NW, 1, number of write ports (1..4).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  NR*AW  read addresses, port i at [i*AW +: AW].
- rd  out  NR*XLEN  read data, port i at [i*XLEN +: XLEN].
- rbusy  out  NR  read port i register has a pending write.
- we  in  NW  write enables.
- wa  in  NW*AW  write addresses.
- wd  in  NW*XLEN  write data.
- iss_v  in  1  issue of an instruction that writes iss_rd.
- iss_rd  in  AW  destination being issued.
- flush  in  1  clear all busy bits, e.g. on branch mispredict.
- dbg_addr  in  AW  simulation tap address.
- dbg_data  out  XLEN  simulation tap data, rf[dbg_addr], unforwarded.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers go to 0 and all busy bits to 0 immediately.
  - rd, rbusy and dbg_data therefore read 0 while reset is held.
  - Writes, issues and flushes are ignored during reset.
- Register 0:
  - reads always return 0 and rbusy always returns 0.
  - writes and issues to address 0 are discarded.
- Read path:
  - combinational, zero latency: rd[i] = rf[ra[i]] (subject to the optional feature).
  - rbusy[i] = busy[ra[i]].
- Write path:
  - on posedge clk, for each port j with we[j] and wa[j] != 0, rf[wa[j]] <= wd[j].
  - Same-address collision between ports: the highest-index port wins; the others are dropped silently.
- Scoreboard, per register k != 0, next-state priority:
  - flush: busy[k] <= 0.
  - else iss_v && iss_rd == k: busy[k] <= 1. This takes priority over a same-cycle writeback to k, because the new producer is the younger one.
  - else any we[j] with wa[j] == k: busy[k] <= 0.
  - else hold.
- Flush affects only busy bits, never register contents. A simultaneous flush and issue leaves the register not busy.
- Out-of-range addresses cannot occur, since NREGS = 2^AW.
- A write to an address not marked busy is legal: data is written, busy stays 0.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - rd[i] returns the write data of the highest-index port j with we[j] && wa[j] == ra[i] != 0; otherwise rf[ra[i]].
  - rbusy[i] is forced 0 when such a same-cycle write matches and the same register is not issued that cycle.
  - Write-back data is therefore visible in the same cycle it is written, which is what decode expects from the old negedge file.
- Undefined:
  - no forwarding; a written value is visible from the cycle after the write edge.
  - rbusy reflects the registered busy bits only.
- dbg_data is never forwarded in either mode.

Decomposition:
- Shared package/header (config.vh):
  - RF_XLEN, RF_NREGS, RF_NR, RF_NW defaults.
  - RF_ZERO_REG constant (0).
  - RF_WB_BYPASS_EN selection, alongside ENABLE_PIPELINE.
- One sub-module, regfile_fwd_mux:
  - per-read-port combinational priority select across NW write ports with the x0 check.
  - instantiated NR times; absent when RF_WB_BYPASS_EN is undefined.
- Storage and scoreboard stay in regfile_mp.

Test Plan:
- Reset: fill all registers with 0xA5A5A5A5 via port 0, pulse rst_n low mid-cycle -> all rd, dbg_data and rbusy read 0 asynchronously, before the next clk edge.
- x0: write 0xDEADBEEF to address 0 and issue rd=0 -> rd reads 0, rbusy = 0, dbg_data at address 0 reads 0.
- Forwarding: ra[0]=5, write 0x12345678 to r5 in the same cycle.
  - With RF_WB_BYPASS_EN: rd[0] = 0x12345678 that cycle.
  - Without it: rd[0] holds the old value that cycle and shows 0x12345678 the next cycle.
- Collision: NW=2, both ports write r7 (0x1 on port 0, 0x2 on port 1) -> r7 = 0x2 afterwards.
- Scoreboard: issue r9 -> rbusy=1 next cycle; writeback r9 plus issue r9 in the same cycle -> stays 1; writeback alone -> 0 next cycle.
- Flush: issue r3 and r4, then assert flush -> both busy bits 0 next cycle, r3/r4 contents unchanged.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared configuration for the multi-port integer register file.
// Default geometry and the hard-wired zero register index.
package regfile_mp_pkg;

    localparam int RF_XLEN     = 32;
    localparam int RF_NREGS    = 32;
    localparam int RF_NR       = 2;
    localparam int RF_NW       = 1;
    localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-read-port write-back bypass select (present with RF_WB_BYPASS_EN).
// Ports: ra/rf_data in; we/wa/wd write ports in; data/hit out.
`ifdef RF_WB_BYPASS_EN
module regfile_fwd_mux
    import regfile_mp_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int AW   = 5,
    parameter int NW   = RF_NW
) (
    input  logic [AW-1:0]      ra,
    input  logic [XLEN-1:0]    rf_data,
    input  logic [NW-1:0]      we,
    input  logic [NW*AW-1:0]   wa,
    input  logic [NW*XLEN-1:0] wd,
    output logic [XLEN-1:0]    data,
    output logic               hit
);

    // Later ports overwrite earlier matches: highest index wins.
    always_comb begin
        data = rf_data;
        hit  = 1'b0;
        for (int j = 0; j < NW; j++) begin
            if (we[j] && (wa[j*AW +: AW] == ra)
                && (ra != AW'(RF_ZERO_REG))) begin
                data = wd[j*XLEN +: XLEN];
                hit  = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard; x0 reads 0.
// Ports: clk, rst_n, ra/rd/rbusy (NR), we/wa/wd (NW), iss_v/iss_rd, flush,
// dbg_addr/dbg_data. Macro RF_WB_BYPASS_EN enables same-cycle forwarding.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int AW    = $clog2(NREGS),
    parameter int NR    = RF_NR,
    parameter int NW    = RF_NW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NR*AW-1:0]   ra,
    output logic [NR*XLEN-1:0] rd,
    output logic [NR-1:0]      rbusy,
    input  logic [NW-1:0]      we,
    input  logic [NW*AW-1:0]   wa,
    input  logic [NW*XLEN-1:0] wd,
    input  logic               iss_v,
    input  logic [AW-1:0]      iss_rd,
    input  logic               flush,
    input  logic [AW-1:0]      dbg_addr,
    output logic [XLEN-1:0]    dbg_data
);

    localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_REG);

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [XLEN-1:0]  rf_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Ascending port order makes the highest-index port win collisions.
    always_comb begin
        for (int k = 0; k < NREGS; k++) begin
            rf_d[k] = rf_q[k];
        end
        for (int j = 0; j < NW; j++) begin
            if (we[j] && (wa[j*AW +: AW] != ZERO)) begin
                rf_d[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
            end
        end
        rf_d[RF_ZERO_REG] = '0;
    end

    // Applied lowest to highest priority: writeback, issue, flush.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NW; j++) begin
            if (we[j]) begin
                busy_d[wa[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_v) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[RF_ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                rf_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                rf_q[k] <= rf_d[k];
            end
            busy_q <= busy_d;
        end
    end

    assign dbg_data = rf_q[dbg_addr];

`ifdef RF_WB_BYPASS_EN
    // Nothing is written during reset, so nothing may be forwarded either.
    logic [NW-1:0] we_live;
    assign we_live = we & {NW{rst_n}};
`endif

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra_i;
        assign ra_i = ra[i*AW +: AW];
`ifdef RF_WB_BYPASS_EN
        logic [XLEN-1:0] fwd_data;
        logic            fwd_hit;
        logic            iss_hit;

        regfile_fwd_mux #(
            .XLEN(XLEN),
            .AW  (AW),
            .NW  (NW)
        ) u_fwd (
            .ra     (ra_i),
            .rf_data(rf_q[ra_i]),
            .we     (we_live),
            .wa     (wa),
            .wd     (wd),
            .data   (fwd_data),
            .hit    (fwd_hit)
        );

        // A same-cycle issue re-arms the register; keep it busy.
        assign iss_hit = iss_v && (iss_rd == ra_i);
        assign rd[i*XLEN +: XLEN] = fwd_data;
        assign rbusy[i] = busy_q[ra_i] & ~(fwd_hit & ~iss_hit);
`else
        assign rd[i*XLEN +: XLEN] = rf_q[ra_i];
        assign rbusy[i] = busy_q[ra_i];
`endif
    end

endmodule
